// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose : shared types for the pipeline hazard controller (forward selects, memory FSM, stage ids).
// Latency : n/a (types and constants only).
// Backpress: n/a.
package pipe_ctrl_pkg;

   // EX operand source select
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // Data-memory handshake tracking
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } mem_state_t;

   // Stage indices; BR_STAGE is expressed in these terms
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : bundle between the core datapath (master) and the hazard controller (slave).
// Latency : n/a (wiring only).
// Backpress: mem_ready from data memory; pipe_adv/pc_we/ifid_we tell the core to hold.
// Signals : ID-stage instruction fields, redirect, mem_ready -> controller;
//           stall/flush/bubble/forward selects, mem_req, mem_err <- controller.
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_memread;
   logic              id_memwrite;
   logic              redirect;
   logic              mem_ready;

   logic              pc_we;
   logic              ifid_we;
   logic              ifid_flush;
   logic              idex_bubble;
   logic              exmem_flush;
   logic              pipe_adv;
   fwd_sel_t          fwd_a;
   fwd_sel_t          fwd_b;
   logic              mem_req;
   logic              mem_err;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_regwrite, id_memread, id_memwrite, redirect, mem_ready,
      input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pipe_adv,
             fwd_a, fwd_b, mem_req, mem_err
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_regwrite, id_memread, id_memwrite, redirect, mem_ready,
      output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pipe_adv,
             fwd_a, fwd_b, mem_req, mem_err
   );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Purpose : pick the EX operand source for one source register (MEM beats WB, x0 never forwarded).
// Latency : combinational.
// Backpress: none.
// Ports   : rs, MEM/WB rd+regwrite+valid in; sel out.
module fwd_select
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              mem_valid,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              wb_valid,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   output fwd_sel_t          sel
);

   always_comb begin
      sel = FWD_RF;
      if (mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
         sel = FWD_MEM;
      end else if (wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : 5-stage pipeline hazard control: load-use stall, redirect flush, forwarding, memory freeze.
// Latency : controls are combinational from current stage state; stage tracking updates on CLOCK.
// Backpress: mem_ready low on an access freezes the whole pipe (pipe_adv=0) until ready or timeout.
// Ports   : CLOCK, RST_n (async, active-low), hz (pipe_hazard_ctrl_if.slave).
// Config  : PIPE_PERF_EN adds CNT_W and saturating stall_cnt/flush_cnt/memwait_cnt outputs.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int BR_STAGE = 3,
   parameter int MEM_TO_W = 8
`ifdef PIPE_PERF_EN
   ,
   parameter int CNT_W    = 32
`endif
) (
   input  logic              CLOCK,
   input  logic              RST_n,
   pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  memwait_cnt
`endif
);

   localparam logic              BR_IN_MEM = (BR_STAGE == STG_MEM);
   localparam logic [MEM_TO_W-1:0] TO_MAX  = '1;

   // Per-stage tracking copies
   logic              ex_valid, ex_regwrite, ex_memread, ex_memwrite;
   logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
   logic              mem_valid, mem_regwrite, mem_memread, mem_memwrite;
   logic [REG_AW-1:0] mem_rd;
   logic              wb_valid, wb_regwrite;
   logic [REG_AW-1:0] wb_rd;

   mem_state_t          state, state_nxt;
   logic [MEM_TO_W-1:0] to_cnt, to_cnt_inc;
   logic                mem_err_q;
   logic                mem_req, pipe_adv, load_use;
   logic                pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush;
   fwd_sel_t            fwd_a, fwd_b;

   assign to_cnt_inc = to_cnt + MEM_TO_W'(1);

   // ---------------- memory handshake FSM ----------------
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (mem_req && !hz.mem_ready) state_nxt = WAIT;
         WAIT: begin
            if (!mem_req || hz.mem_ready) state_nxt = IDLE;
            // to_cnt holds completed wait cycles; this cycle is the last one allowed
            else if (to_cnt_inc == TO_MAX)  state_nxt = ERR;
         end
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      // ERR drops the access so the pipeline can move past it
      mem_req  = mem_valid && (mem_memread || mem_memwrite) && (state != ERR);
      pipe_adv = (state == ERR) || !(mem_req && !hz.mem_ready);
   end

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         to_cnt    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         if (state_nxt == WAIT) to_cnt <= (state == WAIT) ? to_cnt_inc : MEM_TO_W'(1);
         else                   to_cnt <= '0;
         if (state_nxt == ERR)  mem_err_q <= 1'b1;
      end
   end

   // ---------------- stall / flush decisions ----------------
   assign load_use = ex_valid && ex_memread && (ex_rd != '0) &&
                     ((hz.id_use_rs1 && (hz.id_rs1 == ex_rd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == ex_rd)));

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      if (!pipe_adv) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
      end else if (hz.redirect) begin
         // younger instructions are wrong-path, so the load-use stall is moot
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = BR_IN_MEM;
      end else if (load_use) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // ---------------- stage tracking ----------------
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         ex_valid     <= 1'b0;  ex_regwrite  <= 1'b0;  ex_memread <= 1'b0;  ex_memwrite <= 1'b0;
         ex_rd        <= '0;    ex_rs1       <= '0;    ex_rs2     <= '0;
         mem_valid    <= 1'b0;  mem_regwrite <= 1'b0;  mem_memread <= 1'b0;
         mem_memwrite <= 1'b0;  mem_rd       <= '0;
         wb_valid     <= 1'b0;  wb_regwrite  <= 1'b0;  wb_rd      <= '0;
      end else if (pipe_adv) begin
         ex_valid     <= hz.id_valid && !idex_bubble;
         ex_regwrite  <= hz.id_regwrite;
         ex_memread   <= hz.id_memread;
         ex_memwrite  <= hz.id_memwrite;
         ex_rd        <= hz.id_rd;
         ex_rs1       <= hz.id_rs1;
         ex_rs2       <= hz.id_rs2;
         mem_valid    <= ex_valid && !exmem_flush;
         mem_regwrite <= ex_regwrite;
         mem_memread  <= ex_memread;
         mem_memwrite <= ex_memwrite;
         mem_rd       <= ex_rd;
         wb_valid     <= mem_valid;
         wb_regwrite  <= mem_regwrite;
         wb_rd        <= mem_rd;
      end
   end

   // ---------------- forwarding ----------------
   fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
      .rs(ex_rs1), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .sel(fwd_a)
   );

   fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
      .rs(ex_rs2), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .sel(fwd_b)
   );

   assign hz.pc_we       = pc_we;
   assign hz.ifid_we     = ifid_we;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;
   assign hz.exmem_flush = exmem_flush;
   assign hz.pipe_adv    = pipe_adv;
   assign hz.fwd_a       = fwd_a;
   assign hz.fwd_b       = fwd_b;
   assign hz.mem_req     = mem_req;
   assign hz.mem_err     = mem_err_q;

`ifdef PIPE_PERF_EN
   // ---------------- saturating event counters ----------------
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         memwait_cnt <= '0;
      end else begin
         if (pipe_adv && !hz.redirect && load_use && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (pipe_adv && hz.redirect && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
         if (!pipe_adv && (memwait_cnt != '1))
            memwait_cnt <= memwait_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
